// File: rtl/alu_share_arbiter.sv
// Two-requester front end for one shared ALU: round-robin grant, operand latch,
// one-cycle evaluation and a held, id-tagged response until the consumer takes it.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [2:0]            req0_op,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [2:0]            req1_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_overflow,
  output logic                  resp_carryout,
  output logic                  resp_zero,
  output logic                  resp_err
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [2:0]            r_op;
  logic                  r_id;

  logic                  w_grant_sel;
  logic                  w_accept;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic                  w_add_ovf;
  logic                  w_sub_ovf;
  logic [DATA_WIDTH-1:0] w_alu_result;
  logic                  w_alu_ovf;
  logic                  w_alu_cout;
  logic                  w_alu_zero;
  logic                  w_op_legal;

  // A lone requester wins outright; otherwise the one not served last time.
  assign w_grant_sel = (req0_valid ^ req1_valid) ? req1_valid : ~r_last_grant;
  assign w_accept    = (r_state == S_IDLE) && (w_grant_sel ? req1_valid : req0_valid);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_RESP;
      S_RESP:  if (resp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req0_ready = ~w_grant_sel;
        req1_ready = w_grant_sel;
      end
      S_RESP:  resp_valid = 1'b1;
      default: ;
    endcase
  end

  // The shared ALU: driven only from the operand registers.
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} + {1'b0, ~r_b} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign w_add_ovf = (r_a[DATA_WIDTH-1] == r_b[DATA_WIDTH-1]) &&
                     (w_sum[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);
  assign w_sub_ovf = (r_a[DATA_WIDTH-1] != r_b[DATA_WIDTH-1]) &&
                     (w_diff[DATA_WIDTH-1] != r_a[DATA_WIDTH-1]);

  always_comb begin : alu
    w_alu_result = '0;
    w_alu_ovf    = 1'b0;
    w_alu_cout   = 1'b0;
    case (r_op)
      OP_AND: w_alu_result = r_a & r_b;
      OP_OR:  w_alu_result = r_a | r_b;
      OP_ADD: begin
        w_alu_result = w_sum[DATA_WIDTH-1:0];
        w_alu_ovf    = w_add_ovf;
        w_alu_cout   = w_sum[DATA_WIDTH];
      end
      OP_SUB: begin
        w_alu_result = w_diff[DATA_WIDTH-1:0];
        w_alu_ovf    = w_sub_ovf;
        w_alu_cout   = w_diff[DATA_WIDTH];
      end
      OP_SLT: begin
        // Signed less-than is the sign of A-B corrected by its overflow.
        w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_diff[DATA_WIDTH-1] ^ w_sub_ovf};
        w_alu_ovf    = w_sub_ovf;
        w_alu_cout   = w_diff[DATA_WIDTH];
      end
      default: ;
    endcase
  end

  assign w_alu_zero = (w_alu_result == '0);
  assign w_op_legal = (r_op == OP_AND) || (r_op == OP_OR) || (r_op == OP_ADD) ||
                      (r_op == OP_SUB) || (r_op == OP_SLT);

  // NOTE: operand and response registers are reset explicitly so that
  // an aborted operation leaves nothing visible behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant  <= 1'b1;
      r_a           <= '0;
      r_b           <= '0;
      r_op          <= '0;
      r_id          <= 1'b0;
      resp_id       <= 1'b0;
      resp_result   <= '0;
      resp_overflow <= 1'b0;
      resp_carryout <= 1'b0;
      resp_zero     <= 1'b0;
      resp_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a          <= w_grant_sel ? req1_a  : req0_a;
        r_b          <= w_grant_sel ? req1_b  : req0_b;
        r_op         <= w_grant_sel ? req1_op : req0_op;
        r_id         <= w_grant_sel;
        r_last_grant <= w_grant_sel;
      end
      if (r_state == S_EXEC) begin
        resp_id       <= r_id;
        resp_result   <= w_op_legal ? w_alu_result : '0;
        resp_overflow <= w_op_legal & w_alu_ovf;
        resp_carryout <= w_op_legal & w_alu_cout;
        resp_zero     <= w_op_legal & w_alu_zero;
        resp_err      <= ~w_op_legal;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of arbitration and ALU arithmetic.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

  localparam int W = 32;
  localparam logic [36:0] MASK_ALL = {37{1'b1}};
  localparam logic [36:0] MASK_SLT = {37{1'b1}} ^ 37'd12;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  typedef struct packed {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
  } op_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_op, req1_op;
  logic         resp_valid, resp_ready, resp_id;
  logic [W-1:0] resp_result;
  logic         resp_overflow, resp_carryout, resp_zero, resp_err;
  logic [36:0]  resp_vec;

  int total = 0;
  int bad   = 0;

  // transaction-level model state
  int   busy;
  bit   last_g;
  bit   pend [2];
  op_t  pdata [2];
  op_t  exp_q [$];
  int   acc_cyc [$];
  bit   acc_id [$];
  int   cyc;

  always #5 clk = ~clk;

  assign resp_vec = {resp_id, resp_result, resp_overflow, resp_carryout, resp_zero, resp_err};

  alu_share_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_overflow(resp_overflow),
    .resp_carryout(resp_carryout), .resp_zero(resp_zero), .resp_err(resp_err)
  );

  // Expected {id, result, overflow, carryout, zero, err} from plain arithmetic.
  function automatic logic [36:0] ref_resp(input op_t t);
    longint       sa, sb, s;
    logic [63:0]  ua, ub;
    logic [W-1:0] r;
    logic         v, c, z, e;
    sa = longint'($signed(t.a));
    sb = longint'($signed(t.b));
    ua = {32'd0, t.a};
    ub = {32'd0, t.b};
    r = '0; v = 1'b0; c = 1'b0; e = 1'b0;
    case (t.op)
      3'b000: r = t.a & t.b;
      3'b001: r = t.a | t.b;
      3'b010: begin
        r = t.a + t.b;
        c = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        s = sa + sb;
        v = (s > SMAX) || (s < SMIN);
      end
      3'b110: begin
        r = t.a - t.b;
        c = (t.a >= t.b);
        s = sa - sb;
        v = (s > SMAX) || (s < SMIN);
      end
      3'b111: r = (sa < sb) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
    z = !e && (r == '0);
    return {t.id, r, v, c, z, e};
  endfunction

  function automatic logic [W-1:0] pick_val();
    logic [W-1:0] corner [5];
    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic clear_reqs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom);
    req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom);
  endtask

  // Holds rst across two edges and returns just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    resp_ready = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    busy = 0; last_g = 1'b1; pend[0] = 1'b0; pend[1] = 1'b0;
    exp_q.delete(); acc_cyc.delete(); acc_id.delete(); cyc = 0;
  endtask

  task automatic drive_req(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
  endtask

  // Issues one op from an idle DUT and samples it at T, T+1 and T+2.
  task automatic single_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op, output bit rdy_t, output bit vld_t1,
                           output bit vld_t2, output logic [36:0] got);
    resp_ready = 1'b1;
    drive_req(id, a, b, op);
    @(negedge clk);
    rdy_t = id ? req1_ready : req0_ready;
    @(posedge clk); #1 clear_reqs();
    @(negedge clk);
    vld_t1 = resp_valid;
    @(posedge clk); #1;
    @(negedge clk);
    vld_t2 = resp_valid;
    got = resp_vec;
    @(posedge clk); #1;
  endtask

  // Cycle engine: mode 0 both always valid, mode 1 random, mode 2 drain only.
  task automatic run_engine(input int mode, input int n_cycles);
    bit          gsel;
    logic [1:0]  exp_rdy;
    logic [36:0] exp_v, mask;
    op_t         t;
    for (int k = 0; k < n_cycles; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && mode != 2 && (mode == 0 || $urandom_range(0, 2) != 0)) begin
          pend[r] = 1'b1;
          t.id = r[0]; t.a = pick_val(); t.b = pick_val(); t.op = 3'($urandom_range(0, 7));
          pdata[r] = t;
        end
      end
      clear_reqs();
      if (pend[0]) drive_req(1'b0, pdata[0].a, pdata[0].b, pdata[0].op);
      if (pend[1]) drive_req(1'b1, pdata[1].a, pdata[1].b, pdata[1].op);
      resp_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      gsel    = (pend[0] ^ pend[1]) ? pend[1] : !last_g;
      exp_rdy = (busy == 0) ? {gsel, !gsel} : 2'b00;
      total++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        bad++;
        $display("FAIL readies cyc=%0d: got %b want %b", cyc, {req1_ready, req0_ready}, exp_rdy);
      end
      total++;
      if (resp_valid !== (busy == 1)) begin
        bad++;
        $display("FAIL resp_valid cyc=%0d: got %b want %b", cyc, resp_valid, busy == 1);
      end
      if (busy == 1 && exp_q.size() > 0) begin
        exp_v = ref_resp(exp_q[0]);
        mask  = (exp_q[0].op == 3'b111) ? MASK_SLT : MASK_ALL;
        total++;
        if ((resp_vec & mask) !== exp_v) begin
          bad++;
          $display("FAIL response cyc=%0d op=%b a=%h b=%h: got %h want %h", cyc,
                   exp_q[0].op, exp_q[0].a, exp_q[0].b, resp_vec & mask, exp_v);
        end
      end
      @(posedge clk);
      if (busy == 0 && (pend[0] || pend[1])) begin
        t = pdata[gsel];
        t.id = gsel;
        exp_q.push_back(t);
        acc_cyc.push_back(cyc);
        acc_id.push_back(gsel);
        pend[gsel] = 1'b0;
        last_g = gsel;
        busy = 2;
      end else if (busy == 2) begin
        busy = 1;
      end else if (busy == 1 && resp_ready) begin
        busy = 0;
        void'(exp_q.pop_front());
      end
      cyc++;
      #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid: got %b want 0", resp_valid);
    end
    total++;
    if (resp_vec !== 37'd0) begin
      bad++; $display("FAIL reset_resp_regs: got %h want 0", resp_vec);
    end
    total++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      bad++; $display("FAIL reset_readies: got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    bit rdy, v1, v2;
    logic [36:0] got;
    single_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, rdy, v1, v2, got);
    total++;
    if ({rdy, v1, v2} !== 3'b101) begin
      bad++; $display("FAIL add_latency: ready/v1/v2 got %b want 101", {rdy, v1, v2});
    end
    total++;
    if (got !== {1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL add_overflow: got %h want %h", got,
                      {1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_sub_slt();
    bit rdy, v1, v2;
    logic [36:0] got;
    single_op(1'b1, 32'd5, 32'd5, 3'b110, rdy, v1, v2, got);
    total++;
    if ({rdy, v1, v2} !== 3'b101) begin
      bad++; $display("FAIL sub_latency: ready/v1/v2 got %b want 101", {rdy, v1, v2});
    end
    total++;
    if (got !== {1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sub_equal: got %h want %h", got, {1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    end
    single_op(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111, rdy, v1, v2, got);
    total++;
    if ((got & MASK_SLT) !== {1'b1, 32'd1, 4'b0000}) begin
      bad++; $display("FAIL slt_neg: got %h want %h", got & MASK_SLT, {1'b1, 32'd1, 4'b0000});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_engine(0, 18);
    total++;
    if (acc_id.size() != 6) begin
      bad++; $display("FAIL b2b_count: got %0d want 6", acc_id.size());
    end
    for (int i = 0; i < acc_id.size(); i++) begin
      total++;
      if (acc_id[i] !== i[0]) begin
        bad++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, acc_id[i], i[0]);
      end
      if (i > 0) begin
        total++;
        if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
          bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [36:0] want;
    want = {1'b1, 32'd7, 4'b0000};
    do_reset();
    resp_ready = 1'b0;
    drive_req(1'b1, 32'd3, 32'd4, 3'b010);
    @(posedge clk); #1;
    drive_req(1'b0, 32'd9, 32'd9, 3'b001);
    drive_req(1'b1, 32'd1, 32'd2, 3'b000);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({resp_valid, req1_ready, req0_ready, resp_vec} !== {3'b100, want}) begin
        bad++; $display("FAIL stall_hold[%0d]: got v=%b rdy=%b%b %h want v=1 rdy=00 %h", i,
                        resp_valid, req1_ready, req0_ready, resp_vec, want);
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({resp_valid, req1_ready, req0_ready} !== 3'b100) begin
      bad++; $display("FAIL stall_release: got %b want 100", {resp_valid, req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({resp_valid, req1_ready, req0_ready} !== 3'b001) begin
      bad++; $display("FAIL stall_idle: got %b want 001", {resp_valid, req1_ready, req0_ready});
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({resp_valid, req1_ready, req0_ready} !== 3'b000) begin
      bad++; $display("FAIL stall_reaccept: got %b want 000", {resp_valid, req1_ready, req0_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    bit rdy, v1, v2;
    logic [36:0] got;
    do_reset();
    single_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, rdy, v1, v2, got);
    total++;
    if ({v2, got} !== {1'b1, 1'b0, 32'd0, 4'b0001}) begin
      bad++; $display("FAIL illegal_op: got v=%b %h want v=1 %h", v2, got, {1'b0, 32'd0, 4'b0001});
    end
  endtask

  task automatic test_rst_exec();
    do_reset();
    drive_req(1'b0, 32'd10, 32'd20, 3'b010);
    @(posedge clk); #1 clear_reqs();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({resp_valid, resp_vec} !== 38'd0) begin
      bad++; $display("FAIL rst_exec_now: got %b %h want 0", resp_valid, resp_vec);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0) begin
        bad++; $display("FAIL rst_exec_ghost[%0d]: got %b want 0", i, resp_valid);
      end
      @(posedge clk); #1;
    end
    drive_req(1'b0, 32'd1, 32'd1, 3'b010);
    drive_req(1'b1, 32'd2, 32'd2, 3'b010);
    @(negedge clk);
    total++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      bad++; $display("FAIL rst_tie: got %b want 01", {req1_ready, req0_ready});
    end
    // now abort from RESP with the consumer stalled
    resp_ready = 1'b0;
    @(posedge clk); #1 clear_reqs();
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1) begin
      bad++; $display("FAIL rst_resp_pre: got %b want 1", resp_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({resp_valid, resp_vec} !== 38'd0) begin
      bad++; $display("FAIL rst_resp_now: got %b %h want 0", resp_valid, resp_vec);
    end
    @(posedge clk); #1 rst = 1'b0;
    resp_ready = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    run_engine(1, 400);
    run_engine(2, 30);
    total++;
    if (exp_q.size() != 0 || pend[0] || pend[1]) begin
      bad++; $display("FAIL random_drain: got q=%0d pend=%b%b want empty", exp_q.size(),
                      pend[1], pend[0]);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_rst_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
